// File: rtl/nexi_wb_loader.sv
// nexi_wb_loader: serial boot loader. Parses an address / count / payload byte
// frame from the UART receive path and writes each big-endian 32-bit word to
// memory with single Wishbone write cycles. busy_o holds the CPU in reset
// while a frame is being loaded.
module nexi_wb_loader #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_o
);

    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_ADDR, S_LEN, S_DATA, S_WRITE} state_e;

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;      // byte index within the current field
    logic [31:0]   base_q, base_d;
    logic [15:0]   len_q, len_d;
    logic [31:0]   data_q, data_d;
    logic [15:0]   words_q, words_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;

    logic          accept;
    logic [15:0]   len_next;
    logic [15:0]   words_inc;

    assign rx_ready_o = (state_q != S_WRITE);
    assign accept     = rx_valid_i && rx_ready_o;
    assign len_next   = {len_q[7:0], rx_data_i};
    assign words_inc  = words_q + 16'd1;

    // Next-state logic: frame parsing, bus cycle control and idle timeout.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        len_d   = len_q;
        data_d  = data_q;
        words_d = words_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;

        // The idle counter only runs while waiting for bytes inside a frame.
        if (busy_q && state_q != S_WRITE) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_ADDR: begin
                if (accept) begin
                    base_d = {base_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd0) begin
                        busy_d  = 1'b1;
                        words_d = '0;
                    end
                    if (cnt_q == 2'd3) begin
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d = len_next;
                    if (cnt_q == 2'd1) begin
                        cnt_d = 2'd0;
                        if (len_next == 16'd0) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_ADDR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    data_d = {data_q[23:0], rx_data_i};
                    cnt_d  = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                        cyc_d   = 1'b1;
                        sel_d   = 4'hF;
                        adr_d   = {base_q[31:2], 2'b00} + {14'd0, words_q, 2'b00};
                        dat_d   = {data_q[23:0], rx_data_i};
                    end
                end
            end
            S_WRITE: begin
                // Error termination wins over a simultaneous ack.
                if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_ADDR;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    sel_d   = 4'h0;
                    words_d = words_inc;
                    if (words_inc == len_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            default: state_d = S_ADDR;
        endcase

        if (accept) begin
            tmo_d = '0;
        end else if (busy_q && state_q != S_WRITE && tmo_q == TW'(TIMEOUT - 1)) begin
            // Stalled sender: abandon the frame and drop any partial fields.
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_ADDR;
            cnt_d   = 2'd0;
            tmo_d   = '0;
            base_d  = '0;
            len_d   = '0;
            data_d  = '0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of every other register.
        if (rst_i) begin
            state_q <= S_ADDR;
            cnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            data_q  <= '0;
            words_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            len_q   <= len_d;
            data_q  <= data_d;
            words_q <= words_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = cyc_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign err_o    = err_q;
    assign words_o  = words_q;

endmodule

// File: tb/tb_nexi_wb_loader.sv
// Directed bench for nexi_wb_loader with a programmable wait-state Wishbone
// slave model that logs every write it terminates.
module tb_nexi_wb_loader;

    logic        clk_i;
    logic        rst_i;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i;
    logic        rx_ready_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] words_o;

    nexi_wb_loader #(.TIMEOUT(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rx_data_i  (rx_data_i),
        .rx_valid_i (rx_valid_i),
        .rx_ready_o (rx_ready_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_sel_o   (wb_sel_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_ack_i   (wb_ack_i),
        .wb_err_i   (wb_err_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .words_o    (words_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model controls and logs.
    int ws       = 0;
    int err_word = -1;
    int nwrites  = 0;
    int wait_cnt = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int cyc_cycles = 0;
    logic [31:0] log_adr[$];
    logic [31:0] log_dat[$];
    logic [3:0]  log_sel[$];
    logic        log_we[$];

    int stall;
    int n;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave and monitor: acts at negedges, terminating after ws wait cycles.
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_cyc_o) cyc_cycles++;
            if (done_o)   done_cnt++;
            if (err_o)    err_cnt++;
            if (wb_cyc_o && wb_stb_o && !rst_i) begin
                if (wait_cnt == ws) begin
                    log_adr.push_back(wb_adr_o);
                    log_dat.push_back(wb_dat_o);
                    log_sel.push_back(wb_sel_o);
                    log_we.push_back(wb_we_o);
                    if (nwrites == err_word) wb_err_i = 1'b1;
                    else                     wb_ack_i = 1'b1;
                    nwrites++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, output int stalled);
        int k;
        k = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && k < 200) begin
            @(negedge clk_i);
            k++;
        end
        if (k >= 200) check("rx_ready_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        stalled = k;
    endtask

    task automatic send_word(input logic [31:0] w);
        int s;
        logic [31:0] v;
        v = w;
        for (int i = 3; i >= 0; i--) send_byte(v[i*8 +: 8], s);
    endtask

    task automatic send_hdr(input logic [31:0] base, input logic [15:0] len);
        int s;
        send_word(base);
        send_byte(len[15:8], s);
        send_byte(len[7:0], s);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk_i);
    endtask

    task automatic clear_stats();
        done_cnt = 0;
        err_cnt = 0;
        cyc_cycles = 0;
        nwrites = 0;
        log_adr.delete();
        log_dat.delete();
        log_sel.delete();
        log_we.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},  {31'd0, busy_o}, 32'd0);
        check({tag, "_done"},  {31'd0, done_o}, 32'd0);
        check({tag, "_err"},   {31'd0, err_o}, 32'd0);
        check({tag, "_words"}, {16'd0, words_o}, 32'd0);
        check({tag, "_ready"}, {31'd0, rx_ready_o}, 32'd1);
        check({tag, "_cyc"},   {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check({tag, "_adr"},   wb_adr_o, 32'd0);
        check({tag, "_dat"},   wb_dat_o, 32'd0);
        check({tag, "_sel"},   {28'd0, wb_sel_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i = 8'h00;
        idle(3);
        check_reset_values("reset");
        rst_i = 1'b0;
        idle(2);

        // Two words, zero-wait slave.
        clear_stats();
        ws = 0; err_word = -1;
        send_byte(8'h00, stall);
        check("t1_busy_first", {31'd0, busy_o}, 32'd1);
        send_byte(8'h00, stall);
        send_byte(8'h01, stall);
        send_byte(8'h00, stall);
        send_byte(8'h00, stall);
        send_byte(8'h02, stall);
        send_word(32'hDEADBEEF);
        send_word(32'h01234567);
        idle(4);
        check("t1_nwrites", nwrites, 2);
        check("t1_adr0", log_adr[0], 32'h0000_0100);
        check("t1_dat0", log_dat[0], 32'hDEADBEEF);
        check("t1_sel0", {28'd0, log_sel[0]}, 32'hF);
        check("t1_we0",  {31'd0, log_we[0]}, 32'd1);
        check("t1_adr1", log_adr[1], 32'h0000_0104);
        check("t1_dat1", log_dat[1], 32'h01234567);
        check("t1_cyc_cycles", cyc_cycles, 2);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_words", {16'd0, words_o}, 32'd2);
        check("t1_busy_after", {31'd0, busy_o}, 32'd0);

        // Three wait states, byte presented during the bus cycle.
        clear_stats();
        ws = 3;
        send_hdr(32'h0000_0200, 16'd2);
        send_word(32'h11223344);
        check("t2_ready_low", {31'd0, rx_ready_o}, 32'd0);
        send_byte(8'h55, stall);
        check("t2_stall", stall, 4);
        send_byte(8'h66, stall);
        send_byte(8'h77, stall);
        send_byte(8'h88, stall);
        idle(8);
        check("t2_dat0", log_dat[0], 32'h11223344);
        check("t2_adr1", log_adr[1], 32'h0000_0204);
        check("t2_dat1", log_dat[1], 32'h55667788);
        check("t2_cyc_cycles", cyc_cycles, 8);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_words", {16'd0, words_o}, 32'd2);

        // Empty frame: no bus traffic, done one cycle after the 6th byte.
        clear_stats();
        ws = 0;
        send_hdr(32'h0000_0000, 16'd0);
        check("t3_done_now", {31'd0, done_o}, 32'd1);
        idle(4);
        check("t3_cyc_cycles", cyc_cycles, 0);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_words", {16'd0, words_o}, 32'd0);
        check("t3_busy", {31'd0, busy_o}, 32'd0);

        // Address wrap and unaligned base.
        clear_stats();
        send_hdr(32'hFFFF_FFFC, 16'd2);
        send_word(32'hA5A5A5A5);
        send_word(32'h5A5A5A5A);
        idle(4);
        check("t4_adr0", log_adr[0], 32'hFFFF_FFFC);
        check("t4_adr1", log_adr[1], 32'h0000_0000);
        check("t4_dat1", log_dat[1], 32'h5A5A5A5A);
        clear_stats();
        send_hdr(32'h0000_0103, 16'd1);
        send_word(32'hC0FFEE00);
        idle(4);
        check("t4_unaligned_adr", log_adr[0], 32'h0000_0100);
        check("t4_unaligned_done", done_cnt, 1);

        // Timeout after 7 bytes, then a clean frame.
        clear_stats();
        send_hdr(32'h0000_0200, 16'd1);
        send_byte(8'hAA, stall);
        n = 0;
        while (!err_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("t5_timeout_cycles", n, 16);
        check("t5_busy", {31'd0, busy_o}, 32'd0);
        idle(2);
        check("t5_err_cnt", err_cnt, 1);
        check("t5_cyc_cycles", cyc_cycles, 0);
        clear_stats();
        send_hdr(32'h0000_0300, 16'd1);
        send_word(32'hCAFEF00D);
        idle(4);
        check("t5_reload_adr", log_adr[0], 32'h0000_0300);
        check("t5_reload_dat", log_dat[0], 32'hCAFEF00D);
        check("t5_reload_done", done_cnt, 1);
        check("t5_reload_words", {16'd0, words_o}, 32'd1);

        // Bus error on the second word.
        clear_stats();
        err_word = 1;
        send_hdr(32'h0000_0400, 16'd3);
        send_word(32'h10203040);
        send_word(32'h50607080);
        idle(4);
        check("t6_err_cnt", err_cnt, 1);
        check("t6_done_cnt", done_cnt, 0);
        check("t6_words", {16'd0, words_o}, 32'd1);
        check("t6_busy", {31'd0, busy_o}, 32'd0);
        err_word = -1;

        // Reset in the middle of a wait-stated bus cycle.
        clear_stats();
        ws = 10;
        send_hdr(32'h0000_0500, 16'd1);
        send_word(32'h99887766);
        check("t7_cyc_before", {31'd0, wb_cyc_o}, 32'd1);
        idle(2);
        rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_values("t7");
        rst_i = 1'b0;
        idle(3);
        check("t7_done_cnt", done_cnt, 0);
        check("t7_err_cnt", err_cnt, 0);
        check("t7_nwrites", nwrites, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
